lsm_sequencer: RTL
==================

// Module: lsm_sequencer
// PURPOSE
//  Sequences ARM load/store-multiple (LDM/STM) transfers for the CPU datapath.
//  On START from cu_pepo (issued on LSM_DETECT), walks the 16-bit register list
//  lowest-first, issues one memory word request per register with a MOC handshake,
//  and produces the register select, the byte address and the base writeback value.
//  Pulses LSM_END to hand control back to the control unit.
// PARAMETERS
//  ADDR_W       32   address / base width
//  WORD_BYTES   4    address stride per transferred register
//  MOC_TIMEOUT  255  cycles to wait for MOC before abort (LSM_TIMEOUT_EN only)
// PORTS
//  CLK       in   1       clock, rising edge
//  RESET     in   1       asynchronous, active-low reset
//  START     in   1       begin sequence; sampled only in IDLE
//  REG_LIST  in   16      IR[15:0] register list
//  P_BIT     in   1       IR[24] pre(1)/post(0) index
//  U_BIT     in   1       IR[23] up(1)/down(0)
//  L_BIT     in   1       IR[20] load(1)/store(0)
//  BASE      in   ADDR_W  Rn value, captured on START
//  MOC       in   1       memory operation complete
//  MEM_REQ   out  1       memory request (MOV)
//  MEM_RW    out  1       1 = read (LDM), 0 = write (STM)
//  ADDR      out  ADDR_W  current transfer address
//  REG_SEL   out  4       register currently transferred
//  BUSY      out  1       high in every state except IDLE
//  LSM_END   out  1       one-cycle completion pulse
//  WB_ADDR   out  ADDR_W  Rn writeback value; valid while LSM_END is high
//  ERR       out  1       MOC timeout flag; sticky until the next START
// BEHAVIOUR
//  Reset (RESET=0, async): state=IDLE. All outputs are 0, and all internal
//   registers are cleared. Assertion mid-sequence abandons the transfer at once.
//  FSM: IDLE -> SETUP -> REQ <-> NEXT -> DONE -> IDLE.
//  IDLE:  if START=1, capture REG_LIST, P_BIT, U_BIT, L_BIT and BASE -> SETUP.
//         START while BUSY=1 is ignored.
//  SETUP (1 cycle): n = popcount(list); stride = WORD_BYTES.
//   - IA (P0 U1): addr0 = BASE
//   - IB (P1 U1): addr0 = BASE + 4
//   - DA (P0 U0): addr0 = BASE - 4n + 4
//   - DB (P1 U0): addr0 = BASE - 4n
//   - WB_ADDR = BASE +/- 4n by U_BIT.
//   - If n==0 -> DONE, with no memory access and WB_ADDR=BASE; otherwise -> REQ.
//  REQ: MEM_REQ=1, MEM_RW=L. REG_SEL = lowest set bit of the remaining list.
//   ADDR is the current address. Stay in REQ until MOC=1, then -> NEXT.
//  NEXT (1 cycle, MEM_REQ=0): clear the REG_SEL bit and add 4 to ADDR.
//   -> REQ if bits remain, else -> DONE. MEM_REQ drops for at least one cycle
//   between words, which lets the RAM release MOC.
//  DONE (1 cycle): LSM_END=1, BUSY=1 -> IDLE.
//  Registers always go lowest-numbered first, at ascending addresses.
//  Latency: START at edge k; first MEM_REQ at edge k+2.
//   With zero-wait MOC, n words end with LSM_END at edge k+2+2n.
//  All address arithmetic is modulo 2^ADDR_W; wrap past 0 or 2^ADDR_W-1 is legal.
//  MOC is ignored outside REQ. MOC is sampled in REQ only, including the first REQ cycle.
// CONFIGURATION
//  LSM_TIMEOUT_EN defined: an 8-bit+ watchdog counts REQ cycles.
//   When the count reaches MOC_TIMEOUT with no MOC: set ERR=1, drop MEM_REQ, go to
//   DONE, and skip the remaining registers. LSM_END still pulses; WB_ADDR is unchanged.
//  LSM_TIMEOUT_EN undefined: REQ waits forever for MOC and ERR is tied to 0.
// TESTING
//  1 STM IA, list=16'h000B, BASE=0x100, MOC after 1 cycle -> REG_SEL 0,1,3 at
//    ADDR 0x100,0x104,0x108; MEM_RW=0; WB_ADDR=0x10C; one LSM_END pulse.
//  2 LDM DB, list=16'h8001, BASE=0x20 -> R0 at 0x18, R15 at 0x1C; MEM_RW=1; WB_ADDR=0x18.
//  3 list=0, START -> no MEM_REQ; LSM_END 2 cycles after START; WB_ADDR=BASE.
//  4 START re-asserted while BUSY, and MOC pulsed in IDLE/NEXT -> no effect on
//    sequence or addresses.
//  5 RESET low mid-REQ, during the 2nd word -> all outputs 0 immediately; a new
//    START after release runs cleanly.
//  6 LSM_TIMEOUT_EN, MOC never asserted, MOC_TIMEOUT=8 -> ERR=1 and LSM_END pulse
//    after 8 REQ cycles; ERR clears on the next START.

Source files
------------

// File: rtl/lsm_sequencer.sv
// LDM/STM register-list sequencer: walks REG_LIST lowest-first, one MOC-handshaked word per register.
// Optional MOC watchdog enabled by defining LSM_TIMEOUT_EN.
module lsm_sequencer #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WORD_BYTES  = 4
`ifdef LSM_TIMEOUT_EN
  , parameter int unsigned MOC_TIMEOUT = 255
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [15:0]       REG_LIST,
  input  logic              P_BIT,
  input  logic              U_BIT,
  input  logic              L_BIT,
  input  logic [ADDR_W-1:0] BASE,
  input  logic              MOC,
  output logic              MEM_REQ,
  output logic              MEM_RW,
  output logic [ADDR_W-1:0] ADDR,
  output logic [3:0]        REG_SEL,
  output logic              BUSY,
  output logic              LSM_END,
  output logic [ADDR_W-1:0] WB_ADDR,
  output logic              ERR
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state;
  logic [15:0]       list_q;
  logic              p_q;
  logic              u_q;
  logic [ADDR_W-1:0] base_q;

  logic [15:0]       list_rem_c;
  logic [ADDR_W-1:0] span_c;
  logic [ADDR_W-1:0] addr0_c;
  logic              timeout_c;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  function automatic logic [3:0] lowest_bit(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  // Remaining list once the current register is done, total span, and first address by P/U mode.
  always_comb begin
    list_rem_c = list_q & ~(16'h0001 << REG_SEL);
    span_c     = ADDR_W'(popcount16(list_q)) * STRIDE;
    case ({p_q, u_q})
      2'b01:   addr0_c = base_q;
      2'b11:   addr0_c = base_q + STRIDE;
      2'b00:   addr0_c = base_q - span_c + STRIDE;
      default: addr0_c = base_q - span_c;
    endcase
  end

`ifdef LSM_TIMEOUT_EN
  localparam int unsigned CNT_W = (MOC_TIMEOUT > 255) ? $clog2(MOC_TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] wd_cnt;

  assign timeout_c = (state == S_REQ) && !MOC && (wd_cnt == CNT_W'(MOC_TIMEOUT - 1));

  // Watchdog counts consecutive REQ cycles of the current word; ERR is sticky until the next START.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wd_cnt <= '0;
      ERR    <= 1'b0;
    end else begin
      wd_cnt <= (state == S_REQ) ? wd_cnt + CNT_W'(1) : '0;
      if (state == S_IDLE && START) ERR <= 1'b0;
      else if (timeout_c)           ERR <= 1'b1;
    end
  end
`else
  assign timeout_c = 1'b0;
  assign ERR       = 1'b0;
`endif

  // Sequencer FSM; outputs are registered alongside each state transition.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      list_q  <= '0;
      p_q     <= 1'b0;
      u_q     <= 1'b0;
      base_q  <= '0;
      MEM_REQ <= 1'b0;
      MEM_RW  <= 1'b0;
      ADDR    <= '0;
      REG_SEL <= '0;
      BUSY    <= 1'b0;
      LSM_END <= 1'b0;
      WB_ADDR <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            list_q <= REG_LIST;
            p_q    <= P_BIT;
            u_q    <= U_BIT;
            MEM_RW <= L_BIT;
            base_q <= BASE;
            BUSY   <= 1'b1;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          WB_ADDR <= u_q ? base_q + span_c : base_q - span_c;
          ADDR    <= addr0_c;
          if (list_q == 16'h0000) begin
            LSM_END <= 1'b1;
            state   <= S_DONE;
          end else begin
            REG_SEL <= lowest_bit(list_q);
            MEM_REQ <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (MOC) begin
            MEM_REQ <= 1'b0;
            state   <= S_NEXT;
          end else if (timeout_c) begin
            MEM_REQ <= 1'b0;
            LSM_END <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_NEXT: begin
          list_q <= list_rem_c;
          ADDR   <= ADDR + STRIDE;
          if (list_rem_c != 16'h0000) begin
            REG_SEL <= lowest_bit(list_rem_c);
            MEM_REQ <= 1'b1;
            state   <= S_REQ;
          end else begin
            LSM_END <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          LSM_END <= 1'b0;
          BUSY    <= 1'b0;
          MEM_RW  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
